// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: turns a little-endian byte stream
// (word-count header + payload) into consecutive 32-bit memory writes.
module imem_loader #(
    parameter int unsigned       AWIDTH    = 32,
    parameter int unsigned       DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h0100_0000,
    parameter int unsigned       MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              byte_valid_i,
    input  logic [7:0]        byte_data_i,
    output logic              byte_ready_o,
    output logic [AWIDTH-1:0] addr_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              write_en_o,
    output logic              read_en_o,
    output logic              core_hold_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned IW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q;
    logic [1:0]        bcnt_q;
    logic [23:0]       hdr_q;
    logic [23:0]       word_q;
    logic [IW-1:0]     count_q;
    logic [IW-1:0]     idx_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] data_q;

    logic [31:0]       count_d;
    logic [31:0]       word_d;
    logic [IW-1:0]     idx_d;
    logic [AWIDTH-1:0] addr_d;
    logic              hdr_bad;
    logic              last_byte;
    logic              take;

    // Only the first three bytes are kept; the fourth is merged straight into
    // the completed value on the edge it arrives.
    always_comb begin
        count_d   = {byte_data_i, hdr_q};
        word_d    = {byte_data_i, word_q};
        hdr_bad   = (count_d == 32'd0) || (count_d > 32'(MAX_WORDS));
        idx_d     = idx_q + IW'(1);
        addr_d    = BASE_ADDR + (AWIDTH'(idx_q) << 2);
        last_byte = (bcnt_q == 2'd3);
        take      = byte_valid_i && byte_ready_o;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            bcnt_q  <= 2'd0;
            hdr_q   <= '0;
            word_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        bcnt_q  <= 2'd0;
                        idx_q   <= '0;
                        state_q <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (take) begin
                        bcnt_q <= bcnt_q + 2'd1;
                        hdr_q  <= {byte_data_i, hdr_q[23:8]};
                        if (last_byte) begin
                            bcnt_q  <= 2'd0;
                            // A legal count always fits in IW bits.
                            count_q <= count_d[IW-1:0];
                            state_q <= hdr_bad ? S_ERR : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (take) begin
                        bcnt_q <= bcnt_q + 2'd1;
                        word_q <= {byte_data_i, word_q[23:8]};
                        if (last_byte) begin
                            addr_q  <= addr_d;
                            data_q  <= DWIDTH'(word_d);
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    idx_q   <= idx_d;
                    state_q <= (idx_d == count_q) ? S_DONE : S_DATA;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Strobes and status are pure decodes of the state register, so nothing
    // on the byte interface reaches an output combinationally.
    assign byte_ready_o = (state_q == S_HDR) || (state_q == S_DATA);
    assign write_en_o   = (state_q == S_WRITE);
    assign read_en_o    = 1'b0;
    assign core_hold_o  = (state_q != S_DONE);
    assign done_o       = (state_q == S_DONE);
    assign err_o        = (state_q == S_ERR);
    assign addr_o       = addr_q;
    assign data_o       = data_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances, the second with a base
// address near the top of the address space to exercise wrap-around.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    int          sel = 0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;

    logic        a_ready, a_we, a_re, a_hold, a_done, a_err;
    logic [31:0] a_addr, a_data;
    logic        b_ready, b_we, b_re, b_hold, b_done, b_err;
    logic [31:0] b_addr, b_data;

    logic start_a, start_b;
    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);

    imem_loader dut_a (
        .clk(clk), .rst(rst), .start_i(start_a),
        .byte_valid_i(byte_valid), .byte_data_i(byte_data),
        .byte_ready_o(a_ready), .addr_o(a_addr), .data_o(a_data),
        .write_en_o(a_we), .read_en_o(a_re), .core_hold_o(a_hold),
        .done_o(a_done), .err_o(a_err)
    );

    imem_loader #(.BASE_ADDR(32'hFFFF_FFFC)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b),
        .byte_valid_i(byte_valid), .byte_data_i(byte_data),
        .byte_ready_o(b_ready), .addr_o(b_addr), .data_o(b_data),
        .write_en_o(b_we), .read_en_o(b_re), .core_hold_o(b_hold),
        .done_o(b_done), .err_o(b_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_a[$];
    wr_t         exp_b[$];
    int          checks = 0;
    int          failures = 0;
    int          wr_a = 0;
    int          wr_b = 0;
    int          cyc = 0;
    logic [31:0] pay [4];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every observed write pops and checks one expected write.
    always @(negedge clk) begin
        wr_t e;
        if (a_we) begin
            wr_a++;
            checks++;
            if (a_ready !== 1'b0) begin
                failures++;
                $display("FAIL a_ready_in_write got=%b want=0", a_ready);
            end
            checks++;
            if (exp_a.size() == 0) begin
                failures++;
                $display("FAIL a_unexpected_write addr=%h data=%h", a_addr, a_data);
            end else begin
                e = exp_a.pop_front();
                if (a_addr !== e.addr || a_data !== e.data) begin
                    failures++;
                    $display("FAIL a_write got=%h/%h want=%h/%h", a_addr, a_data, e.addr, e.data);
                end else
                    $display("write A addr=%h data=%h", a_addr, a_data);
            end
        end
        if (b_we) begin
            wr_b++;
            checks++;
            if (b_ready !== 1'b0) begin
                failures++;
                $display("FAIL b_ready_in_write got=%b want=0", b_ready);
            end
            checks++;
            if (exp_b.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected_write addr=%h data=%h", b_addr, b_data);
            end else begin
                e = exp_b.pop_front();
                if (b_addr !== e.addr || b_data !== e.data) begin
                    failures++;
                    $display("FAIL b_write got=%h/%h want=%h/%h", b_addr, b_data, e.addr, e.data);
                end else
                    $display("write B addr=%h data=%h", b_addr, b_data);
            end
        end
    end

    function automatic logic cur_ready();
        return (sel == 1) ? b_ready : a_ready;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int inst);
        sel = inst;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
                byte_valid = 1'b0;
                byte_data = 8'($urandom);
                tick();
            end
        end
        byte_valid = 1'b1;
        byte_data = b;
        n = 0;
        @(negedge clk);
        while (!cur_ready() && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout got=0 want=1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
    endtask

    task automatic run_load(input int inst, input logic [31:0] hdr, input int nwords,
                            input bit gaps, input logic [31:0] base);
        wr_t e;
        for (int i = 0; i < nwords; i++) begin
            e.addr = base + 32'(i * 4);
            e.data = pay[i];
            if (inst == 1) exp_b.push_back(e);
            else exp_a.push_back(e);
        end
        send_word(hdr, gaps);
        for (int i = 0; i < nwords; i++) send_word(pay[i], gaps);
        byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int inst);
        int n;
        n = 0;
        @(negedge clk);
        while (((inst == 1) ? b_done : a_done) !== 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL done_timeout inst=%0d got=0 want=1", inst);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if ({a_ready, a_we, a_re, a_hold, a_done, a_err} !== 6'b000100 || a_addr !== 32'h0 || a_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_a got=%b/%h/%h want=000100/0/0",
                     {a_ready, a_we, a_re, a_hold, a_done, a_err}, a_addr, a_data);
        end
        checks++;
        if ({b_ready, b_we, b_re, b_hold, b_done, b_err} !== 6'b000100 || b_addr !== 32'h0 || b_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_b got=%b/%h/%h want=000100/0/0",
                     {b_ready, b_we, b_re, b_hold, b_done, b_err}, b_addr, b_data);
        end
        tick();
        rst = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_nominal();
        int t0;
        int w0;
        pay[0] = 32'h0000_0013;
        pay[1] = 32'h0010_0093;
        w0 = wr_a;
        pulse_start(0);
        t0 = cyc;
        run_load(0, 32'd2, 2, 1'b0, 32'h0100_0000);
        wait_done(0);
        checks++;
        if (cyc - t0 !== 14 || a_hold !== 1'b0) begin
            failures++;
            $display("FAIL nominal_timing got=%0d/hold=%b want=14/hold=0", cyc - t0, a_hold);
        end
        checks++;
        if (wr_a - w0 !== 2 || exp_a.size() !== 0) begin
            failures++;
            $display("FAIL nominal_writes got=%0d/pending=%0d want=2/0", wr_a - w0, exp_a.size());
        end
        tick();
        $display("test_nominal done");
    endtask

    task automatic test_gaps();
        int w0;
        w0 = wr_a;
        pay[0] = 32'h0000_0013;
        pay[1] = 32'h0010_0093;
        pulse_start(0);
        run_load(0, 32'd2, 2, 1'b1, 32'h0100_0000);
        wait_done(0);
        checks++;
        if (wr_a - w0 !== 2 || exp_a.size() !== 0 || a_hold !== 1'b0) begin
            failures++;
            $display("FAIL gaps_writes got=%0d/pending=%0d/hold=%b want=2/0/0", wr_a - w0, exp_a.size(), a_hold);
        end
        tick();
        $display("test_gaps done");
    endtask

    task automatic test_back_to_back();
        pay[0] = 32'hDEAD_BEEF;
        pulse_start(0);
        checks++;
        if (a_hold !== 1'b1 || a_done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_hold got=%b/%b want=1/0", a_hold, a_done);
        end
        run_load(0, 32'd1, 1, 1'b0, 32'h0100_0000);
        wait_done(0);
        checks++;
        if (a_done !== 1'b1 || a_hold !== 1'b0 || exp_a.size() !== 0) begin
            failures++;
            $display("FAIL b2b_done got=%b/%b/%0d want=1/0/0", a_done, a_hold, exp_a.size());
        end
        tick();
        $display("test_back_to_back done");
    endtask

    task automatic test_errors();
        int w0;
        w0 = wr_a;
        pulse_start(0);
        send_word(32'd0, 1'b0);
        byte_valid = 1'b0;
        tick();
        checks++;
        if (a_err !== 1'b1 || a_hold !== 1'b1 || a_done !== 1'b0 || wr_a !== w0) begin
            failures++;
            $display("FAIL err_zero got=%b/%b/%b/%0d want=1/1/0/0", a_err, a_hold, a_done, wr_a - w0);
        end
        pulse_start(0);
        checks++;
        if (a_err !== 1'b0) begin
            failures++;
            $display("FAIL err_clear got=%b want=0", a_err);
        end
        send_word(32'd1025, 1'b0);
        byte_valid = 1'b0;
        tick();
        checks++;
        if (a_err !== 1'b1 || a_hold !== 1'b1 || wr_a !== w0) begin
            failures++;
            $display("FAIL err_big got=%b/%b/%0d want=1/1/0", a_err, a_hold, wr_a - w0);
        end
        pay[0] = 32'hCAFE_F00D;
        pulse_start(0);
        run_load(0, 32'd1, 1, 1'b0, 32'h0100_0000);
        wait_done(0);
        checks++;
        if (a_err !== 1'b0 || wr_a - w0 !== 1 || exp_a.size() !== 0) begin
            failures++;
            $display("FAIL err_recover got=%b/%0d want=0/1", a_err, wr_a - w0);
        end
        tick();
        $display("test_errors done");
    endtask

    task automatic test_reset_midload();
        int w0;
        w0 = wr_a;
        pulse_start(0);
        send_word(32'd2, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        byte_valid = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({a_ready, a_we, a_hold, a_done, a_err} !== 5'b00100 || a_addr !== 32'h0 || a_data !== 32'h0) begin
            failures++;
            $display("FAIL midload_reset got=%b/%h/%h want=00100/0/0",
                     {a_ready, a_we, a_hold, a_done, a_err}, a_addr, a_data);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (wr_a !== w0 || a_hold !== 1'b1) begin
            failures++;
            $display("FAIL midload_nowrite got=%0d/%b want=0/1", wr_a - w0, a_hold);
        end
        pay[0] = 32'h1111_2222;
        pay[1] = 32'h3333_4444;
        pulse_start(0);
        run_load(0, 32'd2, 2, 1'b0, 32'h0100_0000);
        wait_done(0);
        checks++;
        if (wr_a - w0 !== 2 || exp_a.size() !== 0) begin
            failures++;
            $display("FAIL midload_reload got=%0d want=2", wr_a - w0);
        end
        tick();
        $display("test_reset_midload done");
    endtask

    task automatic test_wrap();
        pay[0] = 32'hA5A5_0001;
        pay[1] = 32'h5A5A_0002;
        pulse_start(1);
        run_load(1, 32'd2, 2, 1'b0, 32'hFFFF_FFFC);
        wait_done(1);
        checks++;
        if (wr_b !== 2 || exp_b.size() !== 0 || b_hold !== 1'b0) begin
            failures++;
            $display("FAIL wrap_writes got=%0d/%0d/%b want=2/0/0", wr_b, exp_b.size(), b_hold);
        end
        tick();
        sel = 0;
        $display("test_wrap done");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_gaps();
        test_back_to_back();
        test_errors();
        test_reset_midload();
        test_wrap();
        checks++;
        if (exp_a.size() !== 0 || exp_b.size() !== 0) begin
            failures++;
            $display("FAIL pending_writes got=%0d/%0d want=0/0", exp_a.size(), exp_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
